bcd_serial_adder_ctrl: RTL and testbench

Sequencing controller that adds two multi-digit packed-BCD operands by time-sharing a single one-digit BCD adder stage, one digit per clock, least-significant digit first. Sits above the one-digit BCD adder datapath and turns it into an N-digit decimal adder with a start/busy/done handshake. It is the team's building block for decimal counters and accumulators that need more than one digit.

---
 rtl/bcd_pkg.sv | 15 +
 rtl/bcd_digit_add.sv | 27 ++
 rtl/bcd_serial_adder_ctrl.sv | 129 ++++++++++++
 tb/tb_bcd_serial_adder_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial packed-BCD adder.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef logic [3:0] digit_t;

  localparam logic [4:0] BCD_MAX  = 5'd9;
  localparam logic [4:0] BCD_CORR = 5'd6;

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational one-digit BCD adder with decimal carry in/out.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  digit_t a_d,
  input  digit_t b_d,
  input  logic   cin,
  output digit_t digit,
  output logic   cout
);

  logic [4:0] raw;
  logic [4:0] corr;

  always_comb begin
    raw  = {1'b0, a_d} + {1'b0, b_d} + {4'b0000, cin};
    corr = raw + BCD_CORR;
    if (raw > BCD_MAX) begin
      digit = corr[3:0];
      cout  = 1'b1;
    end else begin
      digit = raw[3:0];
      cout  = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_adder_ctrl.sv
// N-digit packed-BCD adder that time-shares one digit adder, LSD first,
// with a start/busy/done handshake.
module bcd_serial_adder_ctrl
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                invalid
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = $clog2(DIGITS) + 1;

  state_e          state_q, state_d;
  logic [W-1:0]    op_a_q, op_a_d;
  logic [W-1:0]    op_b_q, op_b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic            invalid_q, invalid_d;

  digit_t          a_dig, b_dig, s_dig;
  logic            dig_cout;

  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if ({1'b0, v[4*i +: 4]} > BCD_MAX) bad = 1'b1;
    end
    return bad;
  endfunction

  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        a_dig = op_a_q[4*i +: 4];
        b_dig = op_b_q[4*i +: 4];
      end
    end
  end

  bcd_digit_add u_digit_add (
    .a_d   (a_dig),
    .b_d   (b_dig),
    .cin   (carry_q),
    .digit (s_dig),
    .cout  (dig_cout)
  );

  always_comb begin
    state_d   = state_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    sum_d     = sum_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    invalid_d = invalid_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = ADD;
          op_a_d    = a;
          op_b_d    = b;
          sum_d     = '0;
          idx_d     = '0;
          carry_d   = 1'b0;
          cout_d    = 1'b0;
          invalid_d = has_bad_digit(a) | has_bad_digit(b);
        end
      end
      ADD: begin
        for (int unsigned i = 0; i < DIGITS; i++) begin
          if (idx_q == IW'(i)) sum_d[4*i +: 4] = s_dig;
        end
        carry_d = dig_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IW'(DIGITS - 1)) begin
          state_d = DONE;
          cout_d  = dig_cout;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_a_q    <= '0;
      op_b_q    <= '0;
      sum_q     <= '0;
      idx_q     <= '0;
      carry_q   <= 1'b0;
      cout_q    <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      sum_q     <= sum_d;
      idx_q     <= idx_d;
      carry_q   <= carry_d;
      cout_q    <= cout_d;
      invalid_q <= invalid_d;
    end
  end

  assign busy    = (state_q == ADD);
  assign done    = (state_q == DONE);
  assign sum     = sum_q;
  assign cout    = cout_q;
  assign invalid = invalid_q;

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Directed bench for the 4-digit serial BCD adder: vector table plus
// handshake, interference, mid-operation reset and back-to-back sequences.
module tb_bcd_serial_adder_ctrl;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, cout, invalid;
  logic [W-1:0] sum;

  int checks = 0;
  int fails  = 0;

  bcd_serial_adder_ctrl #(.DIGITS(DIGITS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .sum     (sum),
    .cout    (cout),
    .invalid (invalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [W-1:0] s;
    logic         c;
    logic         inv;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One start pulse; returns cycles until done (0 if it never came) and busy cycle count.
  task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                        output int lat, output int busy_n, output logic overlap);
    logic seen;
    @(negedge clk);
    start = 1'b1; a = va; b = vb;
    @(negedge clk);
    start = 1'b0; a = W'($urandom); b = W'($urandom);
    lat = 0; busy_n = 0; overlap = 1'b0; seen = 1'b0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      if (c > 1) @(negedge clk);
      if (busy) busy_n++;
      if (busy && done) overlap = 1'b1;
      if (done) begin
        seen = 1'b1;
        lat  = c;
      end
    end
  endtask

  initial begin
    int lat, busy_n, n_done, idx, last;
    logic ovl;
    logic [W-1:0] pa[3], pb[3], ps[3];

    vecs[0] = '{16'h0999, 16'h0001, 16'h1000, 1'b0, 1'b0};
    vecs[1] = '{16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h0006, 16'h0006, 16'h0012, 1'b0, 1'b0};
    vecs[3] = '{16'h000A, 16'h0000, 16'h0010, 1'b0, 1'b1};
    vecs[4] = '{16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0};
    vecs[5] = '{16'h0909, 16'h0909, 16'h1818, 1'b0, 1'b0};
    vecs[6] = '{16'hFFFF, 16'hFFFF, 16'h5554, 1'b1, 1'b1};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    #12;
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    chk("reset_sum", 32'(sum), 32'h0);
    chk("reset_cout", 32'(cout), 32'h0);
    chk("reset_invalid", 32'(invalid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].va, vecs[i].vb, lat, busy_n, ovl);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(DIGITS + 1));
      chk($sformatf("v%0d_busy_cycles", i), 32'(busy_n), 32'(DIGITS));
      chk($sformatf("v%0d_busy_done_overlap", i), 32'(ovl), 32'h0);
      chk($sformatf("v%0d_sum", i), 32'(sum), 32'(vecs[i].s));
      chk($sformatf("v%0d_cout", i), 32'(cout), 32'(vecs[i].c));
      chk($sformatf("v%0d_invalid", i), 32'(invalid), 32'(vecs[i].inv));
      @(negedge clk);
      chk($sformatf("v%0d_done_one_cycle", i), 32'(done), 32'h0);
      chk($sformatf("v%0d_sum_held", i), 32'(sum), 32'(vecs[i].s));
    end

    // Start pulses and operand churn during ADD must not disturb the operation.
    @(negedge clk);
    start = 1'b1; a = 16'h1234; b = 16'h4321;
    n_done = 0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        chk("churn_sum", 32'(sum), 32'h5555);
      end
      if (c <= 4) begin
        start = (c % 2) == 1;
        a = W'($urandom); b = W'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    chk("churn_done_count", 32'(n_done), 32'h1);

    // Reset in the second ADD cycle discards the operation.
    @(negedge clk);
    start = 1'b1; a = 16'h1234; b = 16'h4321;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("midrst_partial_sum", 32'(sum), 32'h0005);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_done", 32'(done), 32'h0);
    chk("midrst_sum", 32'(sum), 32'h0);
    chk("midrst_cout", 32'(cout), 32'h0);
    chk("midrst_invalid", 32'(invalid), 32'h0);
    n_done = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done) n_done++;
      if (c == 2) rst_n = 1'b1;
    end
    chk("midrst_no_done", 32'(n_done), 32'h0);
    run_op(16'h1234, 16'h4321, lat, busy_n, ovl);
    chk("midrst_restart_latency", 32'(lat), 32'(DIGITS + 1));
    chk("midrst_restart_sum", 32'(sum), 32'h5555);

    // start held high: accepts every DIGITS+2 cycles, new pair loaded at each done.
    pa[0] = 16'h0999; pb[0] = 16'h0001; ps[0] = 16'h1000;
    pa[1] = 16'h2468; pb[1] = 16'h1357; ps[1] = 16'h3825;
    pa[2] = 16'h5000; pb[2] = 16'h4999; ps[2] = 16'h9999;
    repeat (2) @(negedge clk);
    start = 1'b1; a = pa[0]; b = pb[0];
    idx = 0; last = -1;
    for (int c = 0; c < 60 && idx < 3; c++) begin
      @(negedge clk);
      if (busy && done) chk("b2b_overlap", 32'h1, 32'h0);
      if (done) begin
        chk($sformatf("b2b_sum%0d", idx), 32'(sum), 32'(ps[idx]));
        if (last >= 0) chk($sformatf("b2b_spacing%0d", idx), 32'(c - last), 32'(DIGITS + 2));
        last = c;
        idx++;
        if (idx < 3) begin
          a = pa[idx]; b = pb[idx];
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    chk("b2b_done_count", 32'(idx), 32'h3);
    @(negedge clk);
    chk("b2b_done_one_cycle", 32'(done), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
